// File: rtl/add32_byte_sequencer.sv
// add32_byte_sequencer: two-requester adder that computes a+b+cin one
// SLICE_W-bit slice per cycle on a single shared slice adder. Round-robin
// arbitration in IDLE; result is held in DONE until the consumer takes it.
module add32_byte_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req0_cin,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int N_SLICES = WIDTH / SLICE_W;
  localparam int KW       = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [KW-1:0] LAST = KW'(N_SLICES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             r_state;
  logic               r_ptr;       // 0: req0 wins a tie, 1: req1 wins
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [KW-1:0]      r_k;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_id;
  logic               r_rsp_valid;
  logic               r_busy;

  logic               w_gnt1;
  logic               w_idle;
  logic               w_xfer;
  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic [SLICE_W-1:0] w_s;
  logic               w_c;

  // Round-robin grant: a lone requester always wins, a tie goes to r_ptr.
  // Readys are gated by rst_n so nothing is offered while reset is held.
  assign w_gnt1     = req1_valid & (~req0_valid | r_ptr);
  assign w_idle     = rst_n & (r_state == IDLE);
  assign req0_ready = w_idle & ~w_gnt1;
  assign req1_ready = w_idle &  w_gnt1;
  assign w_xfer     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // The one shared slice adder; operand slice chosen by the slice index.
  assign w_sa       = r_a[r_k*SLICE_W +: SLICE_W];
  assign w_sb       = r_b[r_k*SLICE_W +: SLICE_W];
  assign {w_c, w_s} = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE_W{1'b0}}, r_carry};

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_id    = r_id;
  assign busy      = r_busy;

  // Sequencer FSM: accept in IDLE, one slice per cycle in ADD, hold in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_a     <= w_gnt1 ? req1_a   : req0_a;
            r_b     <= w_gnt1 ? req1_b   : req0_b;
            r_carry <= w_gnt1 ? req1_cin : req0_cin;
            r_id    <= w_gnt1;
            r_ptr   <= ~w_gnt1;
            r_k     <= '0;
            r_state <= ADD;
            r_busy  <= 1'b1;
          end
        end
        ADD: begin
          r_sum[r_k*SLICE_W +: SLICE_W] <= w_s;
          r_carry <= w_c;
          r_k     <= r_k + KW'(1);
          if (r_k == LAST) begin
            r_cout      <= w_c;
            r_rsp_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/add32_byte_sequencer.md
ADD32_BYTE_SEQUENCER -- requirements
Module: add32_byte_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/sum width; multiple of SLICE_W.
REQ-002 SHALL have parameter SLICE_W, default 8: adder slice width; N_SLICES = WIDTH/SLICE_W (4 by default).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  each requester has an operation pending.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  each requester's operands are accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-008 SHALL have ports req0_cin / req1_cin  input  1  carry-in.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_sum  output  WIDTH  a+b+cin mod 2^WIDTH.
REQ-012 SHALL have port rsp_cout  output  1  carry out of MSB.
REQ-013 SHALL have port rsp_id  output  1  requester that issued the result (0/1).
REQ-014 SHALL have port busy  output  1  high in states ADD and DONE.

Function
REQ-015 SHALL contain exactly one SLICE_W-bit adder with carry-in, time-shared across slices; no WIDTH-bit adder.
REQ-016 SHALL implement FSM states IDLE, ADD, DONE.
REQ-017 IDLE: the requester granted by round-robin SHALL see its ready high combinationally; the other ready SHALL be low; transfer = valid & ready.
REQ-018 Arbitration: only one valid -> grant it; both valid -> grant the one named by the priority pointer.
REQ-019 On transfer: capture a, b, cin and id; clear slice index to 0; priority pointer -> the other requester; state -> ADD.
REQ-020 ADD: each cycle, add slice k of a and b with the registered carry (cin for k=0); write the result into sum bits [k*SLICE_W +: SLICE_W]; register the carry; increment k.
REQ-021 After slice N_SLICES-1: state -> DONE, rsp_valid high, rsp_cout = final carry; rsp_valid SHALL rise N_SLICES edges after the accepting edge.
REQ-022 DONE: rsp_sum, rsp_cout and rsp_id SHALL be held stable while rsp_valid & !rsp_ready.
REQ-023 DONE with rsp_ready high: rsp_valid -> 0 and state -> IDLE on that edge.
REQ-024 ADD and DONE: both readys SHALL be low; requester inputs are ignored.
REQ-025 SHALL have no arithmetic exceptions; overflow wraps, reflected only in rsp_cout.
REQ-026 Minimum issue interval SHALL be N_SLICES+2 cycles (accept, N_SLICES slices, response handshake).
REQ-027 A requester holding valid while not granted SHALL keep its request; this block SHALL NOT drop it.

Reset
REQ-028 rst_n low at an edge SHALL force:
- state IDLE
- rsp_valid, rsp_sum, rsp_cout, rsp_id, busy = 0
- slice index and carry = 0
- priority pointer -> req0
REQ-029 Reset asserted in ADD or DONE SHALL abandon the operation; no rsp_valid SHALL follow for it.
REQ-030 While rst_n is low, req0_ready and req1_ready SHALL be 0.

Verification
REQ-031 Reset: rst_n low 2 cycles with both valids high -> all outputs 0 throughout; after release, req0_ready is 1 in the first IDLE cycle.
REQ-032 Carry across a byte boundary: req0 a=0x000000FF, b=0x00000001, cin=0 -> 4 cycles after accept, rsp_sum=0x00000100, rsp_cout=0, rsp_id=0.
REQ-033 Full carry ripple: req1 a=0xFFFFFFFF, b=0x00000000, cin=1 -> rsp_sum=0x00000000, rsp_cout=1, rsp_id=1; separately, a=0x80000000, b=0x80000000, cin=0 -> sum=0, cout=1.
REQ-034 Fairness: both valids held high from reset, rsp_ready=1 -> grant order 0,1,0,1; each response carries the matching rsp_id and sum.
REQ-035 Backpressure: rsp_ready low 3 cycles in DONE -> rsp_* stable, both readys 0; rsp_ready high -> IDLE next edge, next accept possible the following cycle.
REQ-036 Reset mid-op: rst_n low in the 2nd ADD cycle -> no rsp_valid; the next op a=0x12345678, b=0x11111111, cin=0 -> sum=0x23456789, cout=0.
